// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter that shares one SPI_Master byte transmitter between the OLED
// engine (requester 0) and the keyboard reader (requester 1); it owns both CS lines and D/C.
module spi_bus_arbiter #(
    parameter int CS_SETUP_CLKS = 2,
    parameter int CS_HOLD_CLKS  = 2,
    parameter int CS_IDLE_CLKS  = 1
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_REQ0,
    input  logic       i_DV0,
    input  logic [7:0] i_BYTE0,
    input  logic       i_DC0,
    input  logic       i_LAST0,
    output logic       o_GNT0,
    output logic       o_ACK0,
    output logic       o_DONE0,
    input  logic       i_REQ1,
    input  logic       i_DV1,
    input  logic [7:0] i_BYTE1,
    input  logic       i_DC1,
    input  logic       i_LAST1,
    output logic       o_GNT1,
    output logic       o_ACK1,
    output logic       o_DONE1,
    output logic [7:0] o_TX_Byte,
    output logic       o_TX_DV,
    input  logic       i_TX_Ready,
    output logic       o_DC,
    output logic       o_CS0,
    output logic       o_CS1
);

    localparam int SETUP_N = (CS_SETUP_CLKS < 1) ? 1 : CS_SETUP_CLKS;
    localparam int HOLD_N  = (CS_HOLD_CLKS  < 1) ? 1 : CS_HOLD_CLKS;
    localparam int IDLE_N  = (CS_IDLE_CLKS  < 1) ? 1 : CS_IDLE_CLKS;
    localparam logic [15:0] SETUP_LD = 16'(SETUP_N - 1);
    localparam logic [15:0] HOLD_LD  = 16'(HOLD_N - 1);
    localparam logic [15:0] IDLE_LD  = 16'(IDLE_N - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SEND  = 3'd2,
        ST_BUSY  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_byte_q, last_byte_d;
    logic        seen_low_q, seen_low_d;
    logic        wait_q, wait_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_dv_q, tx_dv_d;
    logic        dc_q, dc_d;
    logic        cs0_q, cs0_d;
    logic        cs1_q, cs1_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;

    logic        own_req_s;
    logic        own_dv_s;
    logic [7:0]  own_byte_s;
    logic        own_dc_s;
    logic        own_last_s;
    logic        win_s;
    logic        byte_done_s;

    // Steer the current owner's request inputs; the other requester is never looked at.
    always_comb begin
        own_req_s  = 1'b0;
        own_dv_s   = 1'b0;
        own_byte_s = 8'h00;
        own_dc_s   = 1'b0;
        own_last_s = 1'b0;
        if (owner_q) begin
            own_req_s  = i_REQ1;
            own_dv_s   = i_DV1;
            own_byte_s = i_BYTE1;
            own_dc_s   = i_DC1;
            own_last_s = i_LAST1;
        end else begin
            own_req_s  = i_REQ0;
            own_dv_s   = i_DV0;
            own_byte_s = i_BYTE0;
            own_dc_s   = i_DC0;
            own_last_s = i_LAST0;
        end
    end

    // Transaction sequencer: next state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        last_byte_d = last_byte_q;
        seen_low_d  = seen_low_q;
        wait_d      = wait_q;
        tx_byte_d   = tx_byte_q;
        tx_dv_d     = 1'b0;
        dc_d        = dc_q;
        cs0_d       = cs0_q;
        cs1_d       = cs1_q;
        gnt0_d      = gnt0_q;
        gnt1_d      = gnt1_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        win_s       = 1'b0;
        byte_done_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_REQ0 && i_REQ1) begin
                    win_s = ~last_q;
                end else if (i_REQ1) begin
                    win_s = 1'b1;
                end else begin
                    win_s = 1'b0;
                end
                if (i_REQ0 || i_REQ1) begin
                    owner_d = win_s;
                    cs0_d   = win_s;
                    cs1_d   = ~win_s;
                    gnt0_d  = ~win_s;
                    gnt1_d  = win_s;
                    cnt_d   = SETUP_LD;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_SEND;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_SEND: begin
                if (own_dv_s && i_TX_Ready) begin
                    tx_byte_d   = own_byte_s;
                    dc_d        = own_dc_s;
                    tx_dv_d     = 1'b1;
                    ack0_d      = ~owner_q;
                    ack1_d      = owner_q;
                    last_byte_d = own_last_s;
                    seen_low_d  = 1'b0;
                    wait_d      = 1'b0;
                    state_d     = ST_BUSY;
                end else if (!own_req_s) begin
                    cnt_d   = HOLD_LD;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_BUSY: begin
                // A master that never drops ready is treated as done two clocks after DV.
                if (seen_low_q) begin
                    byte_done_s = i_TX_Ready;
                end else if (!i_TX_Ready) begin
                    seen_low_d = 1'b1;
                end else if (wait_q) begin
                    byte_done_s = 1'b1;
                end else begin
                    wait_d = 1'b1;
                end
                if (byte_done_s) begin
                    if (last_byte_q) begin
                        cnt_d   = HOLD_LD;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 16'd0) begin
                    cs0_d   = 1'b1;
                    cs1_d   = 1'b1;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    last_d  = owner_q;
                    cnt_d   = IDLE_LD;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                cs0_d   = 1'b1;
                cs1_d   = 1'b1;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= 16'd0;
            last_byte_q <= 1'b0;
            seen_low_q  <= 1'b0;
            wait_q      <= 1'b0;
            tx_byte_q   <= 8'h00;
            tx_dv_q     <= 1'b0;
            dc_q        <= 1'b0;
            cs0_q       <= 1'b1;
            cs1_q       <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            last_byte_q <= last_byte_d;
            seen_low_q  <= seen_low_d;
            wait_q      <= wait_d;
            tx_byte_q   <= tx_byte_d;
            tx_dv_q     <= tx_dv_d;
            dc_q        <= dc_d;
            cs0_q       <= cs0_d;
            cs1_q       <= cs1_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
        end
    end

    assign o_GNT0    = gnt0_q;
    assign o_GNT1    = gnt1_q;
    assign o_ACK0    = ack0_q;
    assign o_ACK1    = ack1_q;
    assign o_DONE0   = done0_q;
    assign o_DONE1   = done1_q;
    assign o_TX_Byte = tx_byte_q;
    assign o_TX_DV   = tx_dv_q;
    assign o_DC      = dc_q;
    assign o_CS0     = cs0_q;
    assign o_CS1     = cs1_q;

endmodule
